// File: rtl/ram_arb_pkg.sv
// Shared definitions for the game-state RAM port arbiter: client indices
// and default parameter values.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      CLI_NONE = 2'd0,
      CLI_CPU  = 2'd1,
      CLI_A    = 2'd2,
      CLI_B    = 2'd3
   } client_e;

   localparam int RESERVED_ADDRS_DEFAULT = 2;
   localparam int STARVE_LIMIT_DEFAULT   = 8;
   localparam int STARVE_CNT_W           = 8;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signal bundle of the RAM port arbiter; the arbiter
// uses the slave modport, the requesters and the RAM use the master modport.
interface ram_port_arbiter_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 12
);
   logic                     cpu_req,   a_req,   b_req;
   logic                     cpu_we,    a_we,    b_we;
   logic [ADDRESS_WIDTH-1:0] cpu_addr,  a_addr,  b_addr;
   logic [DATA_WIDTH-1:0]    cpu_wdata, a_wdata, b_wdata;
   logic                     cpu_gnt,   a_gnt,   b_gnt;
   logic                     cpu_rvalid, a_rvalid, b_rvalid;
   logic [DATA_WIDTH-1:0]    rdata;
   logic                     wr_drop;
   logic                     ram_wEn;
   logic [ADDRESS_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0]    ram_dataIn;
   logic [DATA_WIDTH-1:0]    ram_dataOut;

   modport slave (
      input  cpu_req, a_req, b_req, cpu_we, a_we, b_we,
             cpu_addr, a_addr, b_addr, cpu_wdata, a_wdata, b_wdata,
             ram_dataOut,
      output cpu_gnt, a_gnt, b_gnt, cpu_rvalid, a_rvalid, b_rvalid,
             rdata, wr_drop, ram_wEn, ram_addr, ram_dataIn
   );

   modport master (
      output cpu_req, a_req, b_req, cpu_we, a_we, b_we,
             cpu_addr, a_addr, b_addr, cpu_wdata, a_wdata, b_wdata,
             ram_dataOut,
      input  cpu_gnt, a_gnt, b_gnt, cpu_rvalid, a_rvalid, b_rvalid,
             rdata, wr_drop, ram_wEn, ram_addr, ram_dataIn
   );
endinterface

// File: rtl/ram_port_arbiter_starve_counter.sv
// Saturating wait counter for one low-priority client; flags the client as
// starved once it has waited `limit` cycles.
module starve_counter
   import ram_arb_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    inc,
   input  logic                    clear,
   input  logic [STARVE_CNT_W-1:0] limit,
   output logic                    starved
);
   logic [STARVE_CNT_W-1:0] count;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && count != limit) begin
         count <= count + 1'b1;
      end
   end

   assign starved = (count == limit);
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the game-state RAM port between a priority CPU port and two
// round-robin peripheral clients, with starvation bound and reserved-word write protection.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_WIDTH  = 12,
   parameter int RESERVED_ADDRS = RESERVED_ADDRS_DEFAULT,
   parameter int STARVE_LIMIT   = STARVE_LIMIT_DEFAULT
) (
   input  logic                clk,
   input  logic                reset_n,
   ram_port_arbiter_if.slave   bus
);
   client_e                  winner, rr, owner;
   logic                     a_starved, b_starved;
   logic                     sel_we, reserved_hit;
   logic [ADDRESS_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0]    sel_wdata;

   starve_counter u_starve_a (
      .clk(clk), .reset_n(reset_n),
      .inc(bus.a_req && !bus.a_gnt), .clear(bus.a_gnt || !bus.a_req),
      .limit(STARVE_CNT_W'(STARVE_LIMIT)), .starved(a_starved)
   );

   starve_counter u_starve_b (
      .clk(clk), .reset_n(reset_n),
      .inc(bus.b_req && !bus.b_gnt), .clear(bus.b_gnt || !bus.b_req),
      .limit(STARVE_CNT_W'(STARVE_LIMIT)), .starved(b_starved)
   );

   // Grants are masked during reset so no access can reach the RAM in a reset cycle.
   always_comb begin
      winner = CLI_NONE;
      if (!reset_n)                                            winner = CLI_NONE;
      else if (a_starved && bus.a_req && b_starved && bus.b_req) winner = rr;
      else if (a_starved && bus.a_req)                         winner = CLI_A;
      else if (b_starved && bus.b_req)                         winner = CLI_B;
      else if (bus.cpu_req)                                    winner = CLI_CPU;
      else if (bus.a_req && bus.b_req)                         winner = rr;
      else if (bus.a_req)                                      winner = CLI_A;
      else if (bus.b_req)                                      winner = CLI_B;
   end

   // NOTE: every combinational output gets a default first, so no latch is inferred.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      unique case (winner)
         CLI_CPU: begin sel_we = bus.cpu_we; sel_addr = bus.cpu_addr; sel_wdata = bus.cpu_wdata; end
         CLI_A:   begin sel_we = bus.a_we;   sel_addr = bus.a_addr;   sel_wdata = bus.a_wdata;   end
         CLI_B:   begin sel_we = bus.b_we;   sel_addr = bus.b_addr;   sel_wdata = bus.b_wdata;   end
         default: ;
      endcase
   end

   assign reserved_hit   = (sel_addr < ADDRESS_WIDTH'(RESERVED_ADDRS));
   assign bus.cpu_gnt    = (winner == CLI_CPU);
   assign bus.a_gnt      = (winner == CLI_A);
   assign bus.b_gnt      = (winner == CLI_B);
   assign bus.ram_wEn    = sel_we && !reserved_hit;
   assign bus.ram_addr   = sel_addr;
   assign bus.ram_dataIn = sel_wdata;
   assign bus.rdata      = bus.ram_dataOut;
   assign bus.cpu_rvalid = (owner == CLI_CPU);
   assign bus.a_rvalid   = (owner == CLI_A);
   assign bus.b_rvalid   = (owner == CLI_B);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr          <= CLI_A;
         owner       <= CLI_NONE;
         bus.wr_drop <= 1'b0;
      end else begin
         if (winner == CLI_A)      rr <= CLI_B;
         else if (winner == CLI_B) rr <= CLI_A;
         owner       <= (winner != CLI_NONE && !sel_we) ? winner : CLI_NONE;
         bus.wr_drop <= (winner != CLI_NONE) && sel_we && reserved_hit;
      end
   end
endmodule
